// File: rtl/mem_loader.sv
// Stream-driven memory loader: parses (addr, count) headers, writes the following
// data bytes to memory one at a time, and stops on a zero-count header.
module mem_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] addr,
    output logic [7:0]  dbw,
    output logic        cs,
    output logic        we,
    input  logic        mem_ready,
    output logic        done,
    output logic [15:0] run_addr,
    output logic [7:0]  sum,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        H0    = 3'd0,
        H1    = 3'd1,
        H2    = 3'd2,
        H3    = 3'd3,
        DATA  = 3'd4,
        WRITE = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] count_q, count_d;
    logic [15:0] run_addr_q, run_addr_d;
    logic [7:0]  dbw_q, dbw_d;
    logic [7:0]  sum_q, sum_d;
    logic        cs_q, cs_d;
    logic        done_q, done_d;
    logic        accept;

    // Handshake: a byte moves on a rising edge where in_valid && in_ready; a memory
    // write completes on a rising edge where cs && we && mem_ready.
    assign in_ready = (state_q != WRITE) && (state_q != DONE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= H0;
            addr_q     <= 16'h0000;
            count_q    <= 16'h0000;
            run_addr_q <= 16'h0000;
            dbw_q      <= 8'h00;
            sum_q      <= 8'h00;
            cs_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            run_addr_q <= run_addr_d;
            dbw_q      <= dbw_d;
            sum_q      <= sum_d;
            cs_q       <= cs_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        run_addr_d = run_addr_q;
        dbw_d      = dbw_q;
        sum_d      = sum_q;
        cs_d       = cs_q;
        done_d     = done_q;
        case (state_q)
            H0: if (accept) begin
                addr_d[7:0] = in_data;
                state_d     = H1;
            end
            H1: if (accept) begin
                addr_d[15:8] = in_data;
                state_d      = H2;
            end
            H2: if (accept) begin
                count_d[7:0] = in_data;
                state_d      = H3;
            end
            H3: if (accept) begin
                count_d[15:8] = in_data;
                // A zero-length block terminates the stream; its address is the entry point.
                if ({in_data, count_q[7:0]} != 16'h0000) begin
                    state_d = DATA;
                end else begin
                    run_addr_d = addr_q;
                    done_d     = 1'b1;
                    state_d    = DONE;
                end
            end
            DATA: if (accept) begin
                dbw_d   = in_data;
                cs_d    = 1'b1;
                state_d = WRITE;
            end
            WRITE: if (mem_ready) begin
                addr_d  = addr_q + 16'd1;
                count_d = count_q - 16'd1;
                sum_d   = sum_q + dbw_q;
                cs_d    = 1'b0;
                state_d = (count_q == 16'd1) ? H0 : DATA;
            end
            DONE: state_d = DONE;
            default: state_d = H0;
        endcase
    end

    assign addr      = addr_q;
    assign dbw       = dbw_q;
    assign cs        = cs_q;
    assign we        = cs_q;
    assign done      = done_q;
    assign run_addr  = run_addr_q;
    assign sum       = sum_q;
    assign state_dbg = state_q;

endmodule
